// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// The master modport is the arbiter side, the slave modport is the requester side.
interface rr_arbiter8_if;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      input  en,
      input  req,
      output gnt,
      output gnt_id,
      output gnt_valid,
      output timeout
   );

   modport slave (
      output en,
      output req,
      input  gnt,
      input  gnt_id,
      input  gnt_valid,
      input  timeout
   );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded grant tenure and a forced-release pulse.
// All outputs are registered; a one-cycle idle gap separates consecutive grants.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input logic          clk,
   input logic          rst,
   rr_arbiter8_if.master bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e           state_q;
   logic [2:0]       ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       gnt_q;
   logic [2:0]       gnt_id_q;
   logic             gnt_valid_q;
   logic             timeout_q;

   logic [7:0]       req_rot;
   logic [2:0]       win_off;
   logic [2:0]       win_id_d;
   logic             any_req;

   // Rotate so the pointer position lands in bit 0; the lowest set bit is then the winner offset.
   always_comb begin
      req_rot  = 8'({bus.req, bus.req} >> ptr_q);
      any_req  = |bus.req;
      win_off  = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_off = 3'(k);
         end
      end
      win_id_d = ptr_q + win_off;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 3'd0;
         cnt_q       <= '0;
         gnt_q       <= 8'h00;
         gnt_id_q    <= 3'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timeout_q <= 1'b0;
               if (bus.en && any_req) begin
                  state_q     <= GRANT;
                  gnt_q       <= 8'h01 << win_id_d;
                  gnt_id_q    <= win_id_d;
                  gnt_valid_q <= 1'b1;
                  cnt_q       <= '0;
               end else begin
                  gnt_q       <= 8'h00;
                  gnt_valid_q <= 1'b0;
               end
            end
            GRANT: begin
               // A dropped request wins over the hold limit, so no timeout in that case.
               if (!bus.req[gnt_id_q] || (cnt_q == HOLD_LAST)) begin
                  state_q     <= IDLE;
                  gnt_q       <= 8'h00;
                  gnt_valid_q <= 1'b0;
                  timeout_q   <= bus.req[gnt_id_q];
                  ptr_q       <= gnt_id_q + 3'd1;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               gnt_q       <= 8'h00;
               gnt_valid_q <= 1'b0;
               timeout_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Drives four arbiters (MAX_HOLD 1, 2, 4, 16) with shared stimulus and scoreboards
// their outputs against a per-instance behavioural model of the arbitration rules.
module tb_rr_arbiter8;

   localparam int NDUT = 4;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic [7:0] req;

   logic [7:0] gnt_w   [NDUT];
   logic [2:0] id_w    [NDUT];
   logic       vld_w   [NDUT];
   logic       to_w    [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int H = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
      rr_arbiter8_if u_if ();
      assign u_if.en  = en;
      assign u_if.req = req;
      assign gnt_w[g] = u_if.gnt;
      assign id_w[g]  = u_if.gnt_id;
      assign vld_w[g] = u_if.gnt_valid;
      assign to_w[g]  = u_if.timeout;
      rr_arbiter8 #(.MAX_HOLD(H), .CNT_W(8)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if.master)
      );
   end

   int hold_of [NDUT] = '{1, 2, 4, 16};

   // Reference model state: who owns the resource, for how many cycles, and where the scan starts.
   int m_busy  [NDUT];
   int m_owner [NDUT];
   int m_ten   [NDUT];
   int m_ptr   [NDUT];
   int m_to    [NDUT];

   typedef logic [NDUT-1:0][12:0] exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   function automatic void model_edge(input logic r, input logic e, input logic [7:0] rq);
      for (int d = 0; d < NDUT; d++) begin
         if (r) begin
            m_busy[d] = 0; m_owner[d] = 0; m_ten[d] = 0; m_ptr[d] = 0; m_to[d] = 0;
         end else if (m_busy[d] == 0) begin
            m_to[d] = 0;
            if (e && rq != 8'h00) begin
               for (int k = 0; k < 8; k++) begin
                  if (m_busy[d] == 0 && rq[(m_ptr[d] + k) % 8]) begin
                     m_busy[d]  = 1;
                     m_owner[d] = (m_ptr[d] + k) % 8;
                     m_ten[d]   = 1;
                  end
               end
            end
         end else begin
            m_to[d] = 0;
            if (!rq[m_owner[d]]) begin
               m_busy[d] = 0;
               m_ptr[d]  = (m_owner[d] + 1) % 8;
            end else if (m_ten[d] == hold_of[d]) begin
               m_busy[d] = 0;
               m_to[d]   = 1;
               m_ptr[d]  = (m_owner[d] + 1) % 8;
            end else begin
               m_ten[d]++;
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t x;
      for (int d = 0; d < NDUT; d++) begin
         logic [7:0] g;
         g = (m_busy[d] != 0) ? (8'h01 << m_owner[d]) : 8'h00;
         x[d] = {m_to[d] != 0, m_busy[d] != 0, 3'(m_owner[d]), g};
      end
      return x;
   endfunction

   task automatic step(input logic r, input logic e, input logic [7:0] rq);
      rst = r; en = e; req = rq;
      @(posedge clk);
      model_edge(r, e, rq);
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic repeat_step(input int n, input logic r, input logic e, input logic [7:0] rq);
      for (int i = 0; i < n; i++) step(r, e, rq);
   endtask

   // Monitor: outputs are presented every cycle, so each expected entry is checked half a cycle later.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            cyc++;
            for (int d = 0; d < NDUT; d++) begin
               logic [12:0] act;
               act = {to_w[d], vld_w[d], id_w[d], gnt_w[d]};
               checks++;
               if (act !== x[d]) begin
                  errors++;
                  $display("FAIL out_hold%0d cyc %0d: got to=%b vld=%b id=%0d gnt=%h, want to=%b vld=%b id=%0d gnt=%h",
                           hold_of[d], cyc, act[12], act[11], act[10:8], act[7:0],
                           x[d][12], x[d][11], x[d][10:8], x[d][7:0]);
               end
               checks++;
               if ((gnt_w[d] & (gnt_w[d] - 8'h01)) != 8'h00 || vld_w[d] !== (gnt_w[d] != 8'h00)) begin
                  errors++;
                  $display("FAIL invariant_hold%0d cyc %0d: gnt=%h vld=%b, required one-hot/zero with vld==(gnt!=0)",
                           hold_of[d], cyc, gnt_w[d], vld_w[d]);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; req = 8'hFF;
      // Reset with all requests pending, then release
      repeat_step(2, 1'b1, 1'b1, 8'hFF);
      repeat_step(3, 1'b0, 1'b1, 8'hFF);
      // Single requester 5
      step(1'b1, 1'b1, 8'h00);
      repeat_step(2, 1'b0, 1'b1, 8'h00);
      repeat_step(3, 1'b0, 1'b1, 8'h20);
      repeat_step(3, 1'b0, 1'b1, 8'h00);
      // Rotation over 1,4,7
      step(1'b1, 1'b1, 8'h00);
      repeat_step(14, 1'b0, 1'b1, 8'h92);
      repeat_step(2, 1'b0, 1'b1, 8'h00);
      // Wrap-around after granting 6
      step(1'b1, 1'b1, 8'h00);
      repeat_step(2, 1'b0, 1'b1, 8'h40);
      repeat_step(2, 1'b0, 1'b1, 8'h00);
      repeat_step(8, 1'b0, 1'b1, 8'h41);
      repeat_step(2, 1'b0, 1'b1, 8'h00);
      // Sole requester held past the limit
      repeat_step(10, 1'b0, 1'b1, 8'h08);
      repeat_step(2, 1'b0, 1'b1, 8'h00);
      // en low during and after a grant
      step(1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h04);
      repeat_step(4, 1'b0, 1'b0, 8'h04);
      repeat_step(2, 1'b0, 1'b0, 8'h00);
      repeat_step(3, 1'b0, 1'b0, 8'hFF);
      repeat_step(2, 1'b0, 1'b1, 8'hFF);
      // Reset in the middle of a grant
      step(1'b1, 1'b1, 8'h00);
      repeat_step(2, 1'b0, 1'b1, 8'h20);
      step(1'b1, 1'b1, 8'h81);
      repeat_step(4, 1'b0, 1'b1, 8'h81);
      // Randomized traffic with sparse and dense request patterns
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rq;
         logic       e;
         logic       r;
         rq = 8'($urandom);
         case ($urandom_range(0, 3))
            0: rq = rq & 8'($urandom);
            1: rq = 8'h01 << $urandom_range(0, 7);
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) rq = req;
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 199) == 0);
         step(r, e, rq);
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
